mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, number of busy cycles for mult/multu.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, number of busy cycles for div/divu.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have clk  input  1  rising-edge clock.
REQ-005 SHALL have reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have ISMULTDIV  input  1  E-stage instruction is a mult/div/mfhi/mflo/mthi/mtlo.
REQ-007 SHALL have MULTSel  input  3  op code {funct[3],funct[1:0]}: 000 mfhi, 001 mthi, 010 mflo, 011 mtlo, 100 mult, 101 multu, 110 div, 111 divu.
REQ-008 SHALL have Req  input  1  exception/interrupt flush this cycle; suppresses acceptance.
REQ-009 SHALL have A  input  32  rs operand (forwarded).
REQ-010 SHALL have B  input  32  rt operand (forwarded).
REQ-011 SHALL have Start  output  1  a mult/div is being accepted this cycle.
REQ-012 SHALL have Busy  output  1  a mult/div is in flight.
REQ-013 SHALL have RD  output  32  mfhi/mflo read data.
REQ-014 SHALL have HI  output  32  architectural HI register.
REQ-015 SHALL have LO  output  32  architectural LO register.

Function
REQ-016 SHALL define accept = ISMULTDIV & ~Req & ~Busy; commands with accept low SHALL have no effect.
REQ-017 SHALL drive Start = accept & MULTSel[2], combinationally.
REQ-018 SHALL implement two states, IDLE (Busy=0) and RUN (Busy=1), with a down-counter cnt; Busy = (cnt != 0).
REQ-019 SHALL on an accepted mult/multu/div/divu edge: latch 64-bit result {hi,lo} into temp registers, load cnt with MULT_CYCLES or DIV_CYCLES, enter RUN.
REQ-020 SHALL in RUN decrement cnt each edge; on the edge where cnt==1, write temp to HI/LO and return to IDLE.
REQ-021 SHALL keep Busy high for exactly N cycles after the accepting edge; new HI/LO visible in the first cycle Busy is low.
REQ-022 SHALL keep HI/LO at old values throughout RUN.
REQ-023 SHALL compute mult as signed 32x32->64, multu unsigned; HI=product[63:32], LO=product[31:0].
REQ-024 SHALL compute div/divu with LO=quotient, HI=remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-025 SHALL for divisor B==0 still run DIV_CYCLES busy cycles and leave HI/LO unchanged at completion.
REQ-026 SHALL for signed div 0x80000000 / 0xFFFFFFFF produce LO=0x80000000, HI=0x00000000.
REQ-027 SHALL on accepted mthi/mtlo write A into HI/LO at that edge, with no busy cycles.
REQ-028 SHALL drive RD = HI when MULTSel==000, LO when MULTSel==010, else 0, combinationally from current registers.
REQ-029 SHALL ignore any command (including mthi/mtlo) presented while Busy; upstream stalls guarantee none arrive.
REQ-030 SHALL not cancel an in-flight operation when Req asserts during RUN; it completes normally.
REQ-031 SHALL, when Req and a mult/div coincide in IDLE, not start, keep Start=0, and leave state unchanged.

Reset
REQ-032 SHALL on reset asynchronously clear HI, LO, temp registers and cnt to 0, forcing IDLE; Busy=0, Start=0, RD=0.
REQ-033 SHALL on reset during RUN abort the operation with no HI/LO update after reset release.

Verification
REQ-034 SHALL verify mult A=0xFFFFFFFE, B=0x00000003 -> Start=1 for one cycle, Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-035 SHALL verify div A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> HI/LO unchanged.
REQ-036 SHALL verify mthi A=0x12345678 then mfhi next cycle -> RD=0x12345678 with Busy never asserted; mtlo issued while Busy -> LO unchanged.
REQ-037 SHALL verify mult with Req=1 in same cycle -> Start=0, Busy stays 0, HI/LO unchanged; Req=1 on 3rd busy cycle -> operation still completes on schedule.
REQ-038 SHALL verify reset asserted on 4th busy cycle of div 100/7 -> Busy, HI, LO immediately 0 and remain 0 after release.
REQ-039 SHALL verify back-to-back: mult accepted the first cycle Busy drops after a prior div -> new 5-cycle run starts, prior div results visible in HI/LO meanwhile.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed when the command is accepted, then held back for a fixed number of busy cycles.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ISMULTDIV,
  input  logic [2:0]  MULTSel,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] RD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [63:0]    temp_q, temp_d;
  logic [31:0]    hi_q, hi_d, lo_q, lo_d;
  logic           accept;
  logic [63:0]    result;

  logic signed [63:0] prodS;
  logic [63:0]        prodU;
  logic [31:0]        divB;
  logic signed [31:0] sA, sB, sQ, sR;
  logic [31:0]        uQ, uR;
  logic               sOvf;

  assign Busy   = (cnt_q != '0);
  assign accept = ISMULTDIV & ~Req & ~Busy;
  assign Start  = accept & MULTSel[2];
  assign HI     = hi_q;
  assign LO     = lo_q;

  assign prodS = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prodU = {32'b0, A} * {32'b0, B};

  // A zero divisor is replaced by one so the dividers never see it; the result is discarded anyway.
  assign divB = (B == 32'd0) ? 32'd1 : B;
  assign sA   = A;
  assign sB   = divB;
  assign sQ   = sA / sB;
  assign sR   = sA % sB;
  assign uQ   = A / divB;
  assign uR   = A % divB;
  assign sOvf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  always_comb begin
    result = {hi_q, lo_q};
    unique case (MULTSel[1:0])
      2'b00: result = prodS;
      2'b01: result = prodU;
      2'b10: begin
        if (B == 32'd0)  result = {hi_q, lo_q};
        else if (sOvf)   result = {32'h0000_0000, 32'h8000_0000};
        else             result = {sR, sQ};
      end
      default: result = (B == 32'd0) ? {hi_q, lo_q} : {uR, uQ};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    temp_d  = temp_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (MULTSel[2]) begin
            temp_d  = result;
            cnt_d   = MULTSel[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_d = RUN;
          end else if (MULTSel[1:0] == 2'b01) begin
            hi_d = A;
          end else if (MULTSel[1:0] == 2'b11) begin
            lo_d = A;
          end
        end
      end
      default: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          {hi_d, lo_d} = temp_q;
          state_d      = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      temp_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      temp_q  <= temp_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    RD = '0;
    if (MULTSel == 3'b000)      RD = hi_q;
    else if (MULTSel == 3'b010) RD = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// commands compared against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        ISMULTDIV;
  logic [2:0]  MULTSel;
  logic        Req;
  logic [31:0] A, B;
  logic        Start, Busy;
  logic [31:0] RD, HI, LO;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .ISMULTDIV(ISMULTDIV), .MULTSel(MULTSel),
    .Req(Req), .A(A), .B(B), .Start(Start), .Busy(Busy), .RD(RD),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result {HI,LO}; old is returned when the divisor is zero.
  function automatic logic [63:0] refOp(input logic [2:0] sel, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] old);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              ia, ib, q, r;
    refOp = old;
    case (sel)
      3'b100: begin
        sa = $signed(a); sb = $signed(b);
        refOp = sa * sb;
      end
      3'b101: begin
        ua = a; ub = b;
        refOp = ua * ub;
      end
      3'b110: begin
        if (b == 0) refOp = old;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) refOp = {32'h0, 32'h8000_0000};
        else begin
          ia = a; ib = b;
          q = ia / ib; r = ia % ib;
          refOp = {32'(r), 32'(q)};
        end
      end
      3'b111: if (b != 0) refOp = {a % b, a / b};
      default: refOp = old;
    endcase
  endfunction

  // Called at a falling edge with the unit idle; returns at the falling edge
  // where the result (if any) is first visible. injCycle > 0 injects either
  // an mtlo (injMt=1) or a Req pulse on that busy cycle.
  task automatic applyStimulus(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                               input logic req, input int injCycle, input logic injMt);
    logic [63:0] exp;
    int          n;
    ISMULTDIV = 1'b1; MULTSel = sel; A = a; B = b; Req = req;
    #1;
    checkOutput("Start", 32'(Start), 32'(sel[2] & ~req));
    if (sel == 3'b000) checkOutput("RD_mfhi", RD, mHi);
    if (sel == 3'b010) checkOutput("RD_mflo", RD, mLo);
    @(negedge clk);
    ISMULTDIV = 1'b0; Req = 1'b0;
    if (req || !sel[2]) begin
      if (!req && sel == 3'b001) mHi = a;
      if (!req && sel == 3'b011) mLo = a;
      checkOutput("Busy_idle", 32'(Busy), 32'd0);
      checkOutput("HI_idle", HI, mHi);
      checkOutput("LO_idle", LO, mLo);
      return;
    end
    exp = refOp(sel, a, b, {mHi, mLo});
    n = sel[1] ? DIV_N : MULT_N;
    for (int i = 1; i <= n; i++) begin
      if (i == injCycle) begin
        if (injMt) begin
          ISMULTDIV = 1'b1; MULTSel = 3'b011; A = 32'hDEAD_BEEF;
        end else begin
          Req = 1'b1;
        end
        #1;
        checkOutput("Start_busy", 32'(Start), 32'd0);
      end
      checkOutput("Busy_run", 32'(Busy), 32'd1);
      checkOutput("HI_run", HI, mHi);
      checkOutput("LO_run", LO, mLo);
      @(negedge clk);
      ISMULTDIV = 1'b0; Req = 1'b0;
    end
    {mHi, mLo} = exp;
    checkOutput("Busy_done", 32'(Busy), 32'd0);
    checkOutput("HI_done", HI, mHi);
    checkOutput("LO_done", LO, mLo);
  endtask

  initial begin
    logic [2:0]  rs;
    logic [31:0] ra, rb;
    reset = 1'b1; ISMULTDIV = 1'b0; MULTSel = 3'b000; Req = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_Busy", 32'(Busy), 32'd0);
    checkOutput("rst_Start", 32'(Start), 32'd0);
    checkOutput("rst_RD", RD, 32'd0);
    checkOutput("rst_HI", HI, 32'd0);
    checkOutput("rst_LO", LO, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // mult / multu
    applyStimulus(3'b100, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 0, 1'b0);
    checkOutput("mult_HI", HI, 32'hFFFF_FFFF);
    checkOutput("mult_LO", LO, 32'hFFFF_FFFA);
    applyStimulus(3'b101, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 0, 1'b0);
    checkOutput("multu_HI", HI, 32'h0000_0002);
    checkOutput("multu_LO", LO, 32'hFFFF_FFFA);

    // div / divu by zero
    applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 1'b0);
    checkOutput("div_LO", LO, 32'hFFFF_FFFD);
    checkOutput("div_HI", HI, 32'hFFFF_FFFF);
    applyStimulus(3'b111, 32'd7, 32'd0, 1'b0, 0, 1'b0);
    checkOutput("divu0_HI", HI, 32'hFFFF_FFFF);
    checkOutput("divu0_LO", LO, 32'hFFFF_FFFD);

    // signed overflow
    applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    checkOutput("ovf_LO", LO, 32'h8000_0000);
    checkOutput("ovf_HI", HI, 32'h0000_0000);

    // mthi then mfhi, mtlo then mflo
    applyStimulus(3'b001, 32'h1234_5678, 32'd0, 1'b0, 0, 1'b0);
    applyStimulus(3'b000, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    checkOutput("mfhi_RD", RD, 32'h1234_5678);
    applyStimulus(3'b011, 32'hCAFE_F00D, 32'd0, 1'b0, 0, 1'b0);
    applyStimulus(3'b010, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    checkOutput("mflo_RD", RD, 32'hCAFE_F00D);

    // mtlo while busy is ignored
    applyStimulus(3'b101, 32'd3, 32'd4, 1'b0, 2, 1'b1);
    checkOutput("mtlo_busy_LO", LO, 32'd12);

    // Req coinciding with mult, then Req on third busy cycle
    applyStimulus(3'b100, 32'd9, 32'd9, 1'b1, 0, 1'b0);
    checkOutput("req_LO", LO, 32'd12);
    applyStimulus(3'b100, 32'd6, 32'hFFFF_FFFF, 1'b0, 3, 1'b0);
    checkOutput("req3_LO", LO, 32'hFFFF_FFFA);

    // back-to-back: div then mult in the first idle cycle
    applyStimulus(3'b111, 32'd100, 32'd7, 1'b0, 0, 1'b0);
    applyStimulus(3'b100, 32'd5, 32'd5, 1'b0, 0, 1'b0);
    checkOutput("b2b_LO", LO, 32'd25);

    // reset on the fourth busy cycle of div 100/7
    ISMULTDIV = 1'b1; MULTSel = 3'b110; A = 32'd100; B = 32'd7;
    #1;
    checkOutput("abort_Start", 32'(Start), 32'd1);
    @(negedge clk);
    ISMULTDIV = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_Busy_pre", 32'(Busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_Busy", 32'(Busy), 32'd0);
    checkOutput("abort_HI", HI, 32'd0);
    checkOutput("abort_LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mHi = '0; mLo = '0;
    repeat (12) @(negedge clk);
    checkOutput("abort_Busy_post", 32'(Busy), 32'd0);
    checkOutput("abort_HI_post", HI, 32'd0);
    checkOutput("abort_LO_post", LO, 32'd0);

    // random commands against the model
    for (int k = 0; k < 30; k++) begin
      rs = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      applyStimulus(rs, ra, rb, ($urandom_range(0, 7) == 0), 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
